ghash_ctrl: RTL and testbench

Sequencer for the GHASH stage of the AES-GCM datapath. It owns the hash-key and accumulator registers and accepts 128-bit AAD/ciphertext blocks over a valid/ready handshake. It drives the registered single-cycle GF(2^128) multiplier (`gfmul`, operand-to-result latency 1 clock) to compute X_i = (X_{i-1} ^ B_i)·H, folds in the final length block, and presents the GHASH value to the tag stage.

---
 rtl/ghash_ctrl.sv | 118 +++++++++++
 tb/tb_ghash_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_ctrl.sv
// ghash_ctrl: sequencer for the GHASH stage of AES-GCM.
// Owns the hash key (H) and accumulator (X) registers. It takes 128-bit AAD/ciphertext blocks
// over a valid/ready handshake and drives an external registered GF(2^128) multiplier with a
// latency of 1 clock. Each block computes X_i = (X_{i-1} ^ B_i) * H. It then folds in the
// length block and presents the GHASH value.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   iStart              start a message (honoured in IDLE/DONE only)
//   iHashkey, iLenBlk   H and {len(A),len(C)}, sampled with iStart
//   iBlkValid/oBlkReady block handshake; iBlkData, iBlkLast qualified by iBlkValid
//   oMulA, oMulB        multiplier operands (oMulB holds H)
//   iMulResult          multiplier product, valid one cycle after operands
//   oGhash, oDone       final hash and its one-cycle update pulse
//   oBusy               high in every state except IDLE and DONE
// Bit 0 of every 128-bit bus is the GCM MSB.
module ghash_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         iStart,
  input  logic [0:127] iHashkey,
  input  logic [0:127] iLenBlk,
  input  logic         iBlkValid,
  input  logic [0:127] iBlkData,
  input  logic         iBlkLast,
  output logic         oBlkReady,
  output logic [0:127] oMulA,
  output logic [0:127] oMulB,
  input  logic [0:127] iMulResult,
  output logic [0:127] oGhash,
  output logic         oDone,
  output logic         oBusy
);

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StM1,
    StM2,
    StL1,
    StL2,
    StDone
  } state_e;

  state_e       state_q;
  logic [0:127] x_q;
  logic [0:127] len_q;
  logic         last_q;

  // All outputs are registered and updated alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      len_q     <= '0;
      last_q    <= 1'b0;
      oMulA     <= '0;
      oMulB     <= '0;
      oGhash    <= '0;
      oBlkReady <= 1'b0;
      oDone     <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (iStart) begin
            oMulB <= iHashkey;
            len_q <= iLenBlk;
            x_q   <= '0;
            oBusy <= 1'b1;
            if (iLenBlk == '0) begin
              // Empty message: 0 * H = 0, so the result still flows through the multiplier.
              oMulA   <= '0;
              state_q <= StL1;
            end else begin
              oBlkReady <= 1'b1;
              state_q   <= StAcc;
            end
          end
        end
        StAcc: begin
          if (iBlkValid) begin
            oMulA     <= x_q ^ iBlkData;
            last_q    <= iBlkLast;
            oBlkReady <= 1'b0;
            state_q   <= StM1;
          end
        end
        // Operand is stable at the multiplier; its product is registered at the end of this cycle.
        StM1: state_q <= StM2;
        StM2: begin
          if (last_q) begin
            oMulA   <= iMulResult ^ len_q;
            state_q <= StL1;
          end else begin
            x_q       <= iMulResult;
            oBlkReady <= 1'b1;
            state_q   <= StAcc;
          end
        end
        StL1: state_q <= StL2;
        StL2: begin
          oGhash  <= iMulResult;
          oDone   <= 1'b1;
          oBusy   <= 1'b0;
          state_q <= StDone;
        end
        default: begin
          oBlkReady <= 1'b0;
          oBusy     <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Self-checking bench for ghash_ctrl. It includes a behavioural registered GF(2^128)
// multiplier and computes the expected GHASH from the GCM definition.
module tb_ghash_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         iStart, iBlkValid, iBlkLast, oBlkReady, oDone, oBusy;
  logic [0:127] iHashkey, iLenBlk, iBlkData, oMulA, oMulB, iMulResult, oGhash;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] blk [0:7];

  always #5 clk = ~clk;

  ghash_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .iStart    (iStart),
    .iHashkey  (iHashkey),
    .iLenBlk   (iLenBlk),
    .iBlkValid (iBlkValid),
    .iBlkData  (iBlkData),
    .iBlkLast  (iBlkLast),
    .oBlkReady (oBlkReady),
    .oMulA     (oMulA),
    .oMulB     (oMulB),
    .iMulResult(iMulResult),
    .oGhash    (oGhash),
    .oDone     (oDone),
    .oBusy     (oBusy)
  );

  // GCM multiply: value MSB is GCM bit 0, value bit 0 is GCM bit 127.
  function automatic logic [127:0] gf_mult(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z, v;
    z = '0;
    v = b;
    for (int i = 127; i >= 0; i--) begin
      if (a[i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // Stand-in for gfmul: operands in cycle t, product in cycle t+1.
  always @(posedge clk) iMulResult <= gf_mult(oMulA, oMulB);

  function automatic logic [127:0] ghash_model(input logic [127:0] h, input logic [127:0] len,
                                               input int n);
    logic [127:0] x;
    x = '0;
    for (int i = 0; i < n; i++) x = gf_mult(x ^ blk[i], h);
    return gf_mult(x ^ len, h);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one message and collects observations; the calling test judges them.
  task automatic run_msg(input logic [127:0] h, input logic [127:0] len, input int nblk,
                         input bit rnd, input int pulse_blk, output logic [127:0] ghash,
                         output int done_lat, output int gap_err, output int rdy_seen,
                         output int hold_err, output logic done_after, output bit timeout);
    logic [127:0] old_g;
    int since, i, cyc;
    bit hs;
    old_g = oGhash;
    gap_err = 0; rdy_seen = 0; hold_err = 0; timeout = 0; done_lat = -1;
    ghash = '0; done_after = 1'b1;
    @(negedge clk);
    iStart = 1'b1; iHashkey = h; iLenBlk = len;
    @(negedge clk);
    iStart = 1'b0;
    since = 1;
    i = 0;
    cyc = 0;
    if (nblk > 0) begin
      since = 0;
      iBlkData = blk[0];
      iBlkLast = (nblk == 1);
      iBlkValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (i < nblk && cyc < 400) begin
        if (oBlkReady !== ((i == 0) || since >= 3)) gap_err++;
        if (oGhash !== old_g) hold_err++;
        hs = iBlkValid && oBlkReady;
        @(negedge clk);
        cyc++;
        since++;
        if (hs) begin
          i++;
          since = 1;
          if (i < nblk) iBlkData = blk[i];
          if (pulse_blk == i - 1) begin
            iStart = 1'b1;
            iHashkey = ~h;
          end
        end else if (iStart) begin
          iStart = 1'b0;
          iHashkey = h;
        end
        // Blocks are also offered while the DUT is busy; they must not be consumed.
        iBlkValid = (i < nblk) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        iBlkLast = iBlkValid ? (i == nblk - 1) : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      if (cyc >= 400) timeout = 1;
    end
    iBlkValid = 1'b0;
    iBlkLast = 1'b0;
    iStart = 1'b0;
    iHashkey = h;
    while (!oDone && since < 40) begin
      if (oGhash !== old_g) hold_err++;
      if (oBlkReady) rdy_seen++;
      @(negedge clk);
      since++;
    end
    if (oDone) begin
      done_lat = since;
      ghash = oGhash;
      @(negedge clk);
      done_after = oDone;
    end else begin
      timeout = 1;
    end
  endtask

  task automatic test_reset();
    int busy_cnt;
    int done_cnt;
    @(negedge clk);
    iStart = 1'b1; iHashkey = rand128(); iLenBlk = rand128() | 128'h1;
    @(negedge clk);
    iStart = 1'b0; iBlkValid = 1'b1; iBlkData = rand128(); iBlkLast = 1'b0;
    @(negedge clk);
    iBlkValid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (oBlkReady !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_acc: ready got %b want 1", oBlkReady);
    end
    rst = 1'b1;
    iStart = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({oBlkReady, oDone, oBusy} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {oBlkReady, oDone, oBusy});
    end
    n_cmp++;
    if ({oMulA, oMulB, oGhash} !== 384'h0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h want 0", oMulA, oMulB, oGhash);
    end
    rst = 1'b0;
    iStart = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (oBusy !== 1'b0) busy_cnt++;
      if (oDone !== 1'b0) done_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 0 || done_cnt != 0) begin
      n_err++; $display("FAIL reset_idle: busy %0d done %0d cycles want 0 0", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_identity();
    logic [127:0] g;
    int lat, gap, rdy, hold;
    logic da;
    bit to;
    blk[0] = {16{8'h11}};
    blk[1] = {16{8'h22}};
    run_msg(128'h1 << 127, 128'h100, 2, 0, -1, g, lat, gap, rdy, hold, da, to);
    n_cmp++;
    if (g !== ({16{8'h33}} ^ 128'h100)) begin
      n_err++; $display("FAIL identity_ghash: got %h want %h", g, {16{8'h33}} ^ 128'h100);
    end
    n_cmp++;
    if (lat != 5 || to) begin
      n_err++; $display("FAIL identity_done_lat: got %0d (timeout %0d) want 5", lat, to);
    end
    n_cmp++;
    if (gap != 0) begin
      n_err++; $display("FAIL identity_ready_gaps: got %0d bad cycles want 0", gap);
    end
    n_cmp++;
    if (da !== 1'b0) begin
      n_err++; $display("FAIL identity_done_pulse: done after pulse got %b want 0", da);
    end
  endtask

  task automatic test_empty();
    logic [127:0] g;
    int lat, gap, rdy, hold;
    logic da;
    bit to;
    run_msg(rand128() | 128'h1, 128'h0, 0, 0, -1, g, lat, gap, rdy, hold, da, to);
    n_cmp++;
    if (g !== 128'h0) begin
      n_err++; $display("FAIL empty_ghash: got %h want 0", g);
    end
    n_cmp++;
    if (lat != 3 || to) begin
      n_err++; $display("FAIL empty_done_lat: got %0d (timeout %0d) want 3", lat, to);
    end
    n_cmp++;
    if (rdy != 0) begin
      n_err++; $display("FAIL empty_ready: ready high %0d cycles want 0", rdy);
    end
  endtask

  task automatic test_gcm_tc2();
    logic [127:0] g;
    int lat, gap, rdy, hold;
    logic da;
    bit to;
    blk[0] = 128'h0388dace60b6a392f328c2b971b2fe78;
    run_msg(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h80, 1, 0, -1, g, lat, gap, rdy, hold,
            da, to);
    n_cmp++;
    if (g !== 128'hf38cbb1ad69223dcc3457ae5b6b0f885) begin
      n_err++; $display("FAIL tc2_ghash: got %h want f38cbb1ad69223dcc3457ae5b6b0f885", g);
    end
    n_cmp++;
    if ((g ^ 128'h58e2fccefa7e3061367f1d57a4e7455a) !== 128'hab6e47d42cec13bdf53a67b21257bddf) begin
      n_err++; $display("FAIL tc2_tag: got %h want ab6e47d42cec13bdf53a67b21257bddf",
                        g ^ 128'h58e2fccefa7e3061367f1d57a4e7455a);
    end
    n_cmp++;
    if (lat != 5 || to) begin
      n_err++; $display("FAIL tc2_done_lat: got %0d (timeout %0d) want 5", lat, to);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] g, h, len, exp;
    int lat, gap, rdy, hold;
    logic da;
    bit to;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) blk[k] = rand128();
      h = rand128();
      len = {32'h0, $urandom, 32'h0, $urandom} | 128'h200;
      run_msg(h, len, 4, 1, -1, g, lat, gap, rdy, hold, da, to);
      exp = ghash_model(h, len, 4);
      n_cmp++;
      if (g !== exp || to) begin
        n_err++; $display("FAIL backpressure_ghash[%0d]: got %h want %h (timeout %0d)", r, g, exp,
                          to);
      end
      n_cmp++;
      if (gap != 0) begin
        n_err++; $display("FAIL backpressure_ready[%0d]: got %0d bad cycles want 0", r, gap);
      end
    end
  endtask

  task automatic test_restart();
    logic [127:0] g1, g2, h1, h2, exp;
    int lat, gap, rdy, hold;
    logic da;
    bit to;
    for (int k = 0; k < 3; k++) blk[k] = rand128();
    h1 = rand128();
    run_msg(h1, 128'h180, 3, 0, 0, g1, lat, gap, rdy, hold, da, to);
    exp = ghash_model(h1, 128'h180, 3);
    n_cmp++;
    if (g1 !== exp || to) begin
      n_err++; $display("FAIL restart_ignored_start: got %h want %h (timeout %0d)", g1, exp, to);
    end
    for (int k = 0; k < 2; k++) blk[k] = rand128();
    h2 = rand128();
    run_msg(h2, 128'h100, 2, 0, -1, g2, lat, gap, rdy, hold, da, to);
    exp = ghash_model(h2, 128'h100, 2);
    n_cmp++;
    if (g2 !== exp || to) begin
      n_err++; $display("FAIL restart_second_msg: got %h want %h (timeout %0d)", g2, exp, to);
    end
    n_cmp++;
    if (hold != 0) begin
      n_err++; $display("FAIL restart_hold: oGhash changed early in %0d cycles want 0", hold);
    end
    n_cmp++;
    if (lat != 5) begin
      n_err++; $display("FAIL restart_done_lat: got %0d want 5", lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    iStart = 1'b0; iBlkValid = 1'b0; iBlkLast = 1'b0;
    iHashkey = '0; iLenBlk = '0; iBlkData = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_identity();
    test_empty();
    test_gcm_tc2();
    test_backpressure();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
